// File: rtl/debug_trace_arbiter_if.sv
// Commit-side and serializer-side signal bundle for debug_trace_arbiter.
// master: the arbiter; slave: the core/serializer environment.
interface debug_trace_arbiter_if #(
    parameter int NUM_PORTS = 2,
    parameter int DEPTH     = 8,
    parameter int DROP_W    = 16
);
    logic [1:0]              mode;
    logic                    flush;
    logic [NUM_PORTS-1:0]    cmt_valid;
    logic [32*NUM_PORTS-1:0] cmt_pc;
    logic [32*NUM_PORTS-1:0] cmt_instr;
    logic [32*NUM_PORTS-1:0] cmt_wdata;
    logic                    out_valid;
    logic                    out_ready;
    logic [31:0]             out_pc;
    logic [31:0]             out_instr;
    logic [31:0]             out_wdata;
    logic [1:0]              out_mode;
    logic [$clog2(DEPTH):0]  fifo_level;
    logic [DROP_W-1:0]       drop_cnt;

    modport master (
        input  mode, flush, cmt_valid, cmt_pc, cmt_instr, cmt_wdata, out_ready,
        output out_valid, out_pc, out_instr, out_wdata, out_mode, fifo_level, drop_cnt
    );

    modport slave (
        output mode, flush, cmt_valid, cmt_pc, cmt_instr, cmt_wdata, out_ready,
        input  out_valid, out_pc, out_instr, out_wdata, out_mode, fifo_level, drop_cnt
    );
endinterface

// File: rtl/debug_trace_arbiter.sv
// Merges retired-instruction records from NUM_PORTS commit ports into an ordered FIFO
// feeding the nibble serializer. Define DEBUG_TRACE_DEDUP_EN to drop repeated-PC records.
module debug_trace_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int DEPTH     = 8,
    parameter int DROP_W    = 16
) (
    input logic                   clk,
    input logic                   rst,
    debug_trace_arbiter_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = 98;
    localparam logic [EW-1:0] ENTRY_RST = {2'd1, 96'd0};

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_PARTIAL,
        OCC_FULL
    } occ_t;

    occ_t              occ, occ_next;
    logic [EW-1:0]     mem [DEPTH];
    logic [AW-1:0]     rd_ptr, wr_ptr;
    logic [AW-1:0]     rd_ptr_next, wr_ptr_next;
    logic [LW-1:0]     level, level_next;
    logic [DROP_W-1:0] drop_q, drop_next;
    logic [DROP_W:0]   drop_sum;

    logic              pop;
    logic [31:0]       free;
    logic [31:0]       n_push;
    logic [31:0]       n_drop;
    logic              wr_en  [NUM_PORTS];
    logic [AW-1:0]     wr_idx [NUM_PORTS];
    logic [EW-1:0]     entry  [NUM_PORTS];
    logic              elig;
    logic [31:0]       pc_i;

`ifdef DEBUG_TRACE_DEDUP_EN
    logic [31:0]       last_pc, last_pc_next;
`endif

    // Slot allocation: eligible ports claim consecutive slots in port order until space runs out.
    always_comb begin
        pop    = (occ != OCC_EMPTY) && bus.out_ready;
        free   = 32'(DEPTH) - 32'(level) + 32'(pop);
        n_push = '0;
        n_drop = '0;
        elig   = 1'b0;
        pc_i   = '0;
`ifdef DEBUG_TRACE_DEDUP_EN
        last_pc_next = last_pc;
`endif
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            pc_i      = bus.cmt_pc[32*i +: 32];
            entry[i]  = {bus.mode, bus.cmt_wdata[32*i +: 32], bus.cmt_instr[32*i +: 32], pc_i};
            wr_en[i]  = 1'b0;
            wr_idx[i] = '0;
            elig      = bus.cmt_valid[i] && (pc_i != '0);
`ifdef DEBUG_TRACE_DEDUP_EN
            elig      = elig && (pc_i != last_pc_next);
`endif
            if (elig) begin
                if (n_push < free) begin
                    wr_en[i]  = 1'b1;
                    wr_idx[i] = wr_ptr + AW'(n_push);
                    n_push    = n_push + 32'd1;
`ifdef DEBUG_TRACE_DEDUP_EN
                    last_pc_next = pc_i;
`endif
                end else begin
                    n_drop = n_drop + 32'd1;
                end
            end
        end
    end

    always_comb begin
        rd_ptr_next = rd_ptr + AW'(pop);
        wr_ptr_next = wr_ptr + AW'(n_push);
        level_next  = level + LW'(n_push) - LW'(pop);
        drop_sum    = {1'b0, drop_q} + (DROP_W+1)'(n_drop);
        drop_next   = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
        if (bus.flush) begin
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            level_next  = '0;
            drop_next   = drop_q;
        end
        if (level_next == '0)
            occ_next = OCC_EMPTY;
        else if (level_next == LW'(DEPTH))
            occ_next = OCC_FULL;
        else
            occ_next = OCC_PARTIAL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ    <= OCC_EMPTY;
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
            drop_q <= '0;
            for (int unsigned s = 0; s < DEPTH; s++)
                mem[s] <= ENTRY_RST;
        end else begin
            occ    <= occ_next;
            rd_ptr <= rd_ptr_next;
            wr_ptr <= wr_ptr_next;
            level  <= level_next;
            drop_q <= drop_next;
            for (int unsigned i = 0; i < NUM_PORTS; i++)
                if (wr_en[i] && !bus.flush)
                    mem[wr_idx[i]] <= entry[i];
        end
    end

`ifdef DEBUG_TRACE_DEDUP_EN
    always_ff @(posedge clk) begin
        if (rst || bus.flush)
            last_pc <= '0;
        else
            last_pc <= last_pc_next;
    end
`endif

    assign bus.out_valid = (occ != OCC_EMPTY);
    assign {bus.out_mode, bus.out_wdata, bus.out_instr, bus.out_pc} = mem[rd_ptr];
    assign bus.fifo_level = level;
    assign bus.drop_cnt   = drop_q;
endmodule

// File: tb/tb_debug_trace_arbiter.sv
// Directed scoreboard bench for debug_trace_arbiter (NUM_PORTS=2, DEPTH=8, DROP_W=16).
module tb_debug_trace_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [97:0] sb [$];

    always #5 clk = ~clk;

    debug_trace_arbiter_if #(.NUM_PORTS(2), .DEPTH(8), .DROP_W(16)) bus ();

    debug_trace_arbiter #(.NUM_PORTS(2), .DEPTH(8), .DROP_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [97:0] obs, input logic [97:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [97:0] rec(input logic [1:0] m, input logic [31:0] pc,
                                        input logic [31:0] instr, input logic [31:0] wd);
        return {m, wd, instr, pc};
    endfunction

    task automatic clear_cmt();
        bus.cmt_valid = '0;
        bus.cmt_pc    = '0;
        bus.cmt_instr = '0;
        bus.cmt_wdata = '0;
    endtask

    task automatic set_port(input int i, input logic [31:0] pc, input logic [31:0] instr,
                            input logic [31:0] wd);
        bus.cmt_valid[i]         = 1'b1;
        bus.cmt_pc[32*i +: 32]    = pc;
        bus.cmt_instr[32*i +: 32] = instr;
        bus.cmt_wdata[32*i +: 32] = wd;
    endtask

    // Any record transferred at the coming edge is checked against the scoreboard head.
    task automatic tick();
        logic [97:0] exp;
        @(negedge clk);
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_pop", 98'(sb.size()), 98'd1);
            end else begin
                exp = sb.pop_front();
                chk("pop_rec", {bus.out_mode, bus.out_wdata, bus.out_instr, bus.out_pc}, exp);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 24 && sb.size() != 0; k++)
            tick();
        chk("drain_empty", 98'(sb.size()), 98'd0);
    endtask

    initial begin
        rst = 1'b1;
        bus.mode = 2'd0;
        bus.flush = 1'b0;
        bus.out_ready = 1'b0;
        clear_cmt();
        @(posedge clk);
        #1;
        tick();
        tick();
        chk("rst_valid", 98'(bus.out_valid), 98'd0);
        chk("rst_pc",    98'(bus.out_pc),    98'd0);
        chk("rst_mode",  98'(bus.out_mode),  98'd1);
        chk("rst_level", 98'(bus.fifo_level), 98'd0);
        chk("rst_drop",  98'(bus.drop_cnt),  98'd0);
        rst = 1'b0;

        // Single record, consumed immediately
        bus.mode = 2'd2;
        bus.out_ready = 1'b1;
        set_port(0, 32'h1c000000, 32'h02800c0c, 32'd5);
        sb.push_back(rec(2'd2, 32'h1c000000, 32'h02800c0c, 32'd5));
        tick();
        clear_cmt();
        chk("single_valid", 98'(bus.out_valid), 98'd1);
        chk("single_level", 98'(bus.fifo_level), 98'd1);
        tick();
        chk("single_level_after", 98'(bus.fifo_level), 98'd0);
        chk("single_sb", 98'(sb.size()), 98'd0);

        // Dual commit ordering
        bus.mode = 2'd1;
        bus.out_ready = 1'b0;
        set_port(0, 32'h100, 32'hA0, 32'hB0);
        set_port(1, 32'h104, 32'hA4, 32'hB4);
        sb.push_back(rec(2'd1, 32'h100, 32'hA0, 32'hB0));
        sb.push_back(rec(2'd1, 32'h104, 32'hA4, 32'hB4));
        tick();
        clear_cmt();
        chk("dual_level", 98'(bus.fifo_level), 98'd2);
        bus.out_ready = 1'b1;
        tick();
        chk("dual_level_mid", 98'(bus.fifo_level), 98'd1);
        tick();
        chk("dual_level_end", 98'(bus.fifo_level), 98'd0);
        chk("dual_sb", 98'(sb.size()), 98'd0);

        // Fill to DEPTH, then overflow
        bus.out_ready = 1'b0;
        bus.mode = 2'd0;
        for (int c = 0; c < 4; c++) begin
            set_port(0, 32'h1000 + 32'(8*c), 32'(c), 32'(10*c));
            set_port(1, 32'h1004 + 32'(8*c), 32'(c+100), 32'(10*c+1));
            sb.push_back(rec(2'd0, 32'h1000 + 32'(8*c), 32'(c), 32'(10*c)));
            sb.push_back(rec(2'd0, 32'h1004 + 32'(8*c), 32'(c+100), 32'(10*c+1)));
            tick();
        end
        clear_cmt();
        chk("fill_level", 98'(bus.fifo_level), 98'd8);
        set_port(0, 32'h200, 32'h1, 32'h2);
        set_port(1, 32'h204, 32'h3, 32'h4);
        tick();
        clear_cmt();
        chk("ovf_level", 98'(bus.fifo_level), 98'd8);
        chk("ovf_drop",  98'(bus.drop_cnt),   98'd2);

        // Pop and push at full
        bus.mode = 2'd2;
        bus.out_ready = 1'b1;
        set_port(0, 32'h300, 32'h33, 32'h44);
        sb.push_back(rec(2'd2, 32'h300, 32'h33, 32'h44));
        tick();
        clear_cmt();
        chk("full_pp_level", 98'(bus.fifo_level), 98'd8);
        chk("full_pp_drop",  98'(bus.drop_cnt),   98'd2);
        drain();
        chk("drain_level", 98'(bus.fifo_level), 98'd0);

        // pc==0 filter, then flush
        bus.out_ready = 1'b0;
        bus.mode = 2'd1;
        set_port(0, 32'h0, 32'h9, 32'h9);
        set_port(1, 32'h40, 32'h41, 32'h42);
        sb.push_back(rec(2'd1, 32'h40, 32'h41, 32'h42));
        tick();
        clear_cmt();
        chk("pc0_level", 98'(bus.fifo_level), 98'd1);
        chk("pc0_head",  {bus.out_mode, bus.out_wdata, bus.out_instr, bus.out_pc},
            rec(2'd1, 32'h40, 32'h41, 32'h42));
        bus.flush = 1'b1;
        set_port(0, 32'h44, 32'h45, 32'h46);
        tick();
        bus.flush = 1'b0;
        clear_cmt();
        sb.delete();
        chk("flush_level", 98'(bus.fifo_level), 98'd0);
        chk("flush_valid", 98'(bus.out_valid),  98'd0);
        chk("flush_drop",  98'(bus.drop_cnt),   98'd2);
        tick();
        chk("flush_push_gone", 98'(bus.fifo_level), 98'd0);

        // Repeated PC
        set_port(0, 32'h500, 32'h1, 32'h11);
        set_port(1, 32'h500, 32'h2, 32'h12);
        sb.push_back(rec(2'd1, 32'h500, 32'h1, 32'h11));
`ifndef DEBUG_TRACE_DEDUP_EN
        sb.push_back(rec(2'd1, 32'h500, 32'h2, 32'h12));
`endif
        tick();
        clear_cmt();
        set_port(0, 32'h500, 32'h3, 32'h13);
`ifndef DEBUG_TRACE_DEDUP_EN
        sb.push_back(rec(2'd1, 32'h500, 32'h3, 32'h13));
`endif
        tick();
        clear_cmt();
`ifdef DEBUG_TRACE_DEDUP_EN
        chk("dup_level", 98'(bus.fifo_level), 98'd1);
`else
        chk("dup_level", 98'(bus.fifo_level), 98'd3);
`endif
        chk("dup_drop", 98'(bus.drop_cnt), 98'd2);
        bus.out_ready = 1'b1;
        drain();

        // Reset in mid-operation with a transfer pending
        bus.out_ready = 1'b0;
        set_port(0, 32'h600, 32'h61, 32'h62);
        sb.push_back(rec(2'd1, 32'h600, 32'h61, 32'h62));
        tick();
        clear_cmt();
        chk("pre_rst_level", 98'(bus.fifo_level), 98'd1);
        rst = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        chk("mid_rst_level", 98'(bus.fifo_level), 98'd0);
        chk("mid_rst_valid", 98'(bus.out_valid),  98'd0);
        chk("mid_rst_drop",  98'(bus.drop_cnt),   98'd0);
        chk("mid_rst_pc",    98'(bus.out_pc),     98'd0);
        chk("mid_rst_mode",  98'(bus.out_mode),   98'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
